// File: rtl/maze_pkg.sv
// Shared state encoding and pad indices for the maze pad conditioner.
package maze_pkg;

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_RUN  = 2'b01;
    localparam logic [1:0] ST_GOAL = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE = ST_IDLE,
        S_RUN  = ST_RUN,
        S_GOAL = ST_GOAL
    } state_e;

    localparam int PAD_START = 0;
    localparam int PAD_CRASH = 1;
    localparam int PAD_GOAL  = 2;
    localparam int NUM_PADS  = 3;

endpackage

// File: rtl/maze_debounce.sv
// One raw pad: 2-flop synchroniser, hold-time debounce, registered rising-edge strobe.
// Strobe rises together with the accepted stable level; no backpressure, free-running.
module maze_debounce
    import maze_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1000
) (
    input  logic clk,
    input  logic reset,
    input  logic pad_i,
    output logic level_o,
    output logic rise_o
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic          sync_q1;
    logic          sync_q2;
    logic          stable_q;
    logic          rise_q;
    logic [CW-1:0] cnt_q;
    logic          differ;
    logic          accept;

    assign differ = (sync_q2 != stable_q);
    assign accept = differ && (cnt_q == CW'(DEBOUNCE_CYCLES - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q1  <= 1'b0;
            sync_q2  <= 1'b0;
            stable_q <= 1'b0;
            rise_q   <= 1'b0;
            cnt_q    <= '0;
        end else begin
            sync_q1 <= pad_i;
            sync_q2 <= sync_q1;
            // Only a 0->1 acceptance produces a strobe
            rise_q  <= accept && sync_q2;
            if (!differ) begin
                cnt_q <= '0;
            end else if (accept) begin
                stable_q <= sync_q2;
                cnt_q    <= '0;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign level_o = stable_q;
    assign rise_o  = rise_q;

endmodule

// File: rtl/maze_pad_conditioner.sv
// Turns raw start/crash/goal pads into a clean crash pulse and sticky goal level via a game FSM.
// Outputs respond one cycle after the debounced strobe; no backpressure, clear_i overrides everything.
module maze_pad_conditioner
    import maze_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1000,
    parameter int HOLDOFF_CYCLES  = 50000,
    parameter int PULSE_W         = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start_pad_i,
    input  logic       crash_pad_i,
    input  logic       goal_pad_i,
    input  logic       clear_i,
    output logic       crash_n_o,
    output logic       crash_pulse_o,
    output logic       goal_o,
    output logic       running_o,
    output logic [1:0] state_o
);

    localparam int HW = $clog2(HOLDOFF_CYCLES + 1);
    localparam int PW = $clog2(PULSE_W + 1);

    logic [NUM_PADS-1:0] pad_raw;
    logic [NUM_PADS-1:0] pad_level;
    logic [NUM_PADS-1:0] pad_rise;
    logic                unused_levels;

    assign pad_raw[PAD_START] = start_pad_i;
    assign pad_raw[PAD_CRASH] = crash_pad_i;
    assign pad_raw[PAD_GOAL]  = goal_pad_i;
    assign unused_levels      = ^pad_level;

    for (genvar g = 0; g < NUM_PADS; g++) begin : g_pad
        maze_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_debounce (
            .clk    (clk),
            .reset  (reset),
            .pad_i  (pad_raw[g]),
            .level_o(pad_level[g]),
            .rise_o (pad_rise[g])
        );
    end

    state_e        state_q, state_d;
    logic [HW-1:0] holdoff_q, holdoff_d;
    logic [PW-1:0] pulse_q, pulse_d;
    logic          crash_n_q, crash_n_d;
    logic          crash_pulse_q, crash_take;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= S_IDLE;
            holdoff_q     <= '0;
            pulse_q       <= '0;
            crash_n_q     <= 1'b1;
            crash_pulse_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            holdoff_q     <= holdoff_d;
            pulse_q       <= pulse_d;
            crash_n_q     <= crash_n_d;
            crash_pulse_q <= crash_take;
        end
    end

    always_comb begin
        state_d    = state_q;
        holdoff_d  = holdoff_q;
        pulse_d    = pulse_q;
        crash_take = 1'b0;

        if (clear_i) begin
            state_d   = S_IDLE;
            holdoff_d = '0;
            pulse_d   = '0;
        end else begin
            case (state_q)
                S_IDLE: if (pad_rise[PAD_START]) state_d = S_RUN;
                S_RUN: begin
                    crash_take = pad_rise[PAD_CRASH] && (holdoff_q == '0);
                    if (pad_rise[PAD_GOAL]) state_d = S_GOAL;
                end
                S_GOAL:  state_d = S_GOAL;
                default: state_d = S_IDLE;
            endcase

            // Holdoff and pulse timers keep running in every state
            if (crash_take) begin
                holdoff_d = HW'(HOLDOFF_CYCLES);
                pulse_d   = PW'(PULSE_W);
            end else begin
                if (holdoff_q != '0) holdoff_d = holdoff_q - 1'b1;
                if (pulse_q != '0)   pulse_d   = pulse_q - 1'b1;
            end
        end

        // Registered so the counter's crash clock never sees decode glitches
        crash_n_d = (pulse_d == '0);
    end

    assign crash_n_o     = crash_n_q;
    assign crash_pulse_o = crash_pulse_q;
    assign state_o       = state_q;
    assign running_o     = (state_q == S_RUN);
    assign goal_o        = (state_q == S_GOAL);

endmodule

// File: tb/tb_maze_pad_conditioner.sv
// Scoreboarded directed bench: stimulus queues expected events, a negedge monitor matches them.
module tb_maze_pad_conditioner;

    localparam int EV_PULSE = 0;
    localparam int EV_STATE = 1;
    localparam int EV_NLOW  = 2;

    typedef struct {
        int kind;
        int cyc;
        int val;
    } ev_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       start_pad_i, crash_pad_i, goal_pad_i, clear_i;
    logic       crash_n_o, crash_pulse_o, goal_o, running_o;
    logic [1:0] state_o;

    int  cyc = 0;
    int  n_checks = 0;
    int  n_pass = 0;
    bit  mon_en = 1'b0;
    int  low_cnt = 0;
    logic [3:0] prev_st = 4'b0000;
    ev_t exp_q[$];

    maze_pad_conditioner #(
        .DEBOUNCE_CYCLES(4),
        .HOLDOFF_CYCLES (8),
        .PULSE_W        (2)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start_pad_i  (start_pad_i),
        .crash_pad_i  (crash_pad_i),
        .goal_pad_i   (goal_pad_i),
        .clear_i      (clear_i),
        .crash_n_o    (crash_n_o),
        .crash_pulse_o(crash_pulse_o),
        .goal_o       (goal_o),
        .running_o    (running_o),
        .state_o      (state_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic string kname(int k);
        case (k)
            EV_PULSE: return "pulse";
            EV_STATE: return "state";
            default:  return "crash_n_low_width";
        endcase
    endfunction

    function automatic void push(int k, int c, int v);
        ev_t e;
        e.kind = k;
        e.cyc  = c;
        e.val  = v;
        exp_q.push_back(e);
    endfunction

    task automatic chk(string name, int act, int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic check_ev(int k, int v);
        ev_t e;
        n_checks++;
        if (exp_q.size() == 0) begin
            $display("FAIL unexpected %s event at cycle %0d value %0d", kname(k), cyc, v);
        end else begin
            e = exp_q.pop_front();
            if (e.kind == k && e.cyc == cyc && e.val == v)
                n_pass++;
            else
                $display("FAIL event: got %s cyc=%0d val=%0d expected %s cyc=%0d val=%0d",
                         kname(k), cyc, v, kname(e.kind), e.cyc, e.val);
        end
    endtask

    // Monitor: fixed per-cycle order pulse, state tuple, crash_n low width
    always @(negedge clk) begin
        if (mon_en) begin
            if (crash_pulse_o) check_ev(EV_PULSE, 1);
            if ({goal_o, running_o, state_o} != prev_st) begin
                check_ev(EV_STATE, int'({goal_o, running_o, state_o}));
                prev_st = {goal_o, running_o, state_o};
            end
            if (!crash_n_o) low_cnt++;
            else if (low_cnt != 0) begin
                check_ev(EV_NLOW, low_cnt);
                low_cnt = 0;
            end
        end
    end

    task automatic tick(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    int e;

    initial begin
        reset = 1'b0;
        start_pad_i = 1'b0;
        crash_pad_i = 1'b0;
        goal_pad_i  = 1'b0;
        clear_i     = 1'b0;
        #23 reset = 1'b1;
        tick(3);
        chk("rst_crash_n", crash_n_o, 1);
        chk("rst_crash_pulse", crash_pulse_o, 0);
        chk("rst_goal", goal_o, 0);
        chk("rst_running", running_o, 0);
        chk("rst_state", state_o, 0);
        mon_en = 1'b1;

        // crash in IDLE: nothing happens
        crash_pad_i = 1'b1; tick(6); crash_pad_i = 1'b0; tick(15);

        // 3-cycle start glitch: filtered
        start_pad_i = 1'b1; tick(3); start_pad_i = 1'b0; tick(15);

        // clean start: RUN 7 edges after the raw edge
        e = cyc; start_pad_i = 1'b1; push(EV_STATE, e + 7, 4'b0101);
        tick(10); start_pad_i = 1'b0; tick(15);

        // held crash: one strobe, crash_n low 2 cycles
        e = cyc; crash_pad_i = 1'b1;
        push(EV_PULSE, e + 7, 1); push(EV_NLOW, e + 9, 2);
        tick(10); crash_pad_i = 1'b0; tick(20);

        // bouncy crash: single-cycle bursts then contact settles high
        e = cyc;
        push(EV_PULSE, e + 15, 1); push(EV_NLOW, e + 17, 2);
        for (int i = 0; i < 8; i++) begin
            crash_pad_i = (i % 2 == 0);
            tick(1);
        end
        crash_pad_i = 1'b1; tick(8);
        crash_pad_i = 1'b0; tick(1);
        crash_pad_i = 1'b1; tick(1);
        crash_pad_i = 1'b0; tick(20);

        // two clean crashes 12 cycles apart
        e = cyc;
        push(EV_PULSE, e + 7, 1);  push(EV_NLOW, e + 9, 2);
        push(EV_PULSE, e + 19, 1); push(EV_NLOW, e + 21, 2);
        crash_pad_i = 1'b1; tick(5); crash_pad_i = 1'b0; tick(7);
        crash_pad_i = 1'b1; tick(5); crash_pad_i = 1'b0; tick(20);

        // crash and goal together: pulse and GOAL on the same edge
        e = cyc;
        push(EV_PULSE, e + 7, 1); push(EV_STATE, e + 7, 4'b1010); push(EV_NLOW, e + 9, 2);
        crash_pad_i = 1'b1; goal_pad_i = 1'b1;
        tick(6); crash_pad_i = 1'b0; goal_pad_i = 1'b0; tick(15);

        // crash in GOAL: ignored
        crash_pad_i = 1'b1; tick(6); crash_pad_i = 1'b0; tick(20);

        // clear out of GOAL, then restart
        e = cyc; clear_i = 1'b1; push(EV_STATE, e + 1, 4'b0000);
        tick(1); clear_i = 1'b0; tick(2);
        e = cyc; start_pad_i = 1'b1; push(EV_STATE, e + 7, 4'b0101);
        tick(6); start_pad_i = 1'b0; tick(20);

        // clear during crash_n low phase, then crash before old holdoff would expire
        e = cyc; crash_pad_i = 1'b1; push(EV_PULSE, e + 7, 1);
        tick(4); crash_pad_i = 1'b0; tick(3);
        clear_i = 1'b1; start_pad_i = 1'b1;
        push(EV_STATE, e + 8, 4'b0000); push(EV_NLOW, e + 8, 1);
        tick(1);
        clear_i = 1'b0; crash_pad_i = 1'b1;
        push(EV_STATE, e + 14, 4'b0101); push(EV_PULSE, e + 15, 1); push(EV_NLOW, e + 17, 2);
        tick(4); crash_pad_i = 1'b0;
        tick(1); start_pad_i = 1'b0;
        tick(20);

        // async reset in the middle of a crash pulse
        e = cyc; crash_pad_i = 1'b1; push(EV_PULSE, e + 7, 1);
        tick(7);
        @(negedge clk); #1;
        chk("pre_reset_crash_n_low", crash_n_o, 0);
        mon_en = 1'b0;
        reset = 1'b0;
        #1;
        chk("async_reset_crash_n", crash_n_o, 1);
        chk("async_reset_state", state_o, 0);
        chk("async_reset_pulse", crash_pulse_o, 0);
        crash_pad_i = 1'b0;

        while (exp_q.size() != 0) begin
            ev_t m;
            m = exp_q.pop_front();
            n_checks++;
            $display("FAIL missing %s event expected cyc=%0d val=%0d", kname(m.kind), m.cyc, m.val);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
